clock_datapath: RTL and testbench
=================================

CLOCK_DATAPATH -- requirements
Module: clock_datapath

Interface
REQ-001 The block SHALL use one clock, clk; reset is synchronous and active-high, named clear.
REQ-002 Ports SHALL be as listed below, clock and reset first:
- clk  input  1  system clock, all state updates on rising edge
- clear  input  1  synchronous active-high reset
- op_valid  input  1  controller presents a micro-op
- op_ready  output  1  block can accept a micro-op (high only in IDLE)
- src_a  input  4  register index read into latch A
- src_b  input  4  register index read into latch B
- dst  input  4  register index written from result R
- la, lb  input  1 each  load latch A / latch B enables
- kc  input  1  B takes key_data instead of reg[src_b]
- lr  input  1  load result register R from ALU
- er  input  1  write R back to reg[dst]
- ea  input  1  update flags cout/zero/eq
- alu_s  input  2  ALU operation select
- cin  input  1  ALU carry in
- key_data  input  6  keypad value from the timer-set controller
- rd_idx  input  4  observation read index
- rd_data  output  6  reg[rd_idx], combinational; 0 for index >= 10
- cout, zero, eq  output  1 each  registered status flags
- done  output  1  one-cycle pulse at micro-op completion
- bad_dst  output  1  one-cycle pulse when er targets index >= 10

Function
REQ-003 The register file SHALL hold 10 six-bit fields with these indices: 0 sec1, 1 sec2, 2 min1, 3 min2, 4 hour1, 5 hour2, 6 date, 7 month, 8 day, 9 year.
REQ-004 Reads of indices 10-15 SHALL return 0; writes to them SHALL be dropped and SHALL pulse bad_dst in the WRITE cycle.
REQ-005 The FSM SHALL have exactly these states: IDLE -> LATCH -> EXEC -> WRITE -> IDLE, with one cycle in each non-IDLE state.
REQ-006 A micro-op SHALL be accepted on a cycle where op_valid and op_ready are both high; all op fields SHALL be captured into an op register on acceptance.
REQ-007 Op inputs SHALL be ignored while op_ready is low.
REQ-008 In LATCH, A SHALL load reg[src_a] if la, and B SHALL load (kc ? key_data : reg[src_b]) if lb; latches not enabled SHALL hold their value.
REQ-009 In EXEC, R SHALL load the ALU result if lr, else hold.
REQ-010 In EXEC, if ea: cout SHALL take the ALU carry-out, zero SHALL be (ALU result == 0), and eq SHALL be (A == B); otherwise the flags SHALL hold.
REQ-011 In WRITE, if er, reg[dst] SHALL take R; done SHALL be high for exactly this one cycle.
REQ-012 ALU encodings: 00 result = A, carry 0; 01 result = A+B+cin; 10 result = A+~B+cin (subtract when cin=1); 11 result = A+1. All arithmetic is 7-bit internal, result = bits[5:0], cout = bit 6 (modulo-64 wrap).
REQ-013 Latency SHALL be: accept at edge N, done high in the cycle after edge N+2, new register value visible on rd_data after edge N+3.
REQ-014 op_ready SHALL return high in the cycle after WRITE; back-to-back ops SHALL therefore sustain one op per 4 cycles.
REQ-015 With er=1 and lr=0, WRITE SHALL write the previously held R.
REQ-016 With src_a == dst, A SHALL be the pre-write value.

Reset
REQ-017 clear SHALL have priority over everything; on a clear edge the FSM SHALL go to IDLE and all of these SHALL become 0: registers, A, B, R, cout, zero, eq, done, bad_dst.
REQ-018 After the clear edge, op_ready SHALL be 1.
REQ-019 clear asserted mid-op SHALL abort the op with no register write; op_valid coincident with clear SHALL NOT be accepted.

Structure
REQ-020 Shared package clock_pkg SHALL hold the field index constants (0-9), the ALU encodings, the FSM state encoding, and the width constant 6.
REQ-021 The ALU SHALL be a separate combinational sub-module dp_alu (A, B, S, cin -> result, cout); the FSM and register file SHALL be in clock_datapath.

Verification
REQ-022 After clear, the bench SHALL show op_ready=1, all rd_data=0, and flags=0.
REQ-023 Keypad load: kc=1, key_data=37, lb=1, la=0 with A=0, alu_s=01, cin=0, lr=1, er=1, dst=2 -> done 3 cycles after accept, reg[2]=37.
REQ-024 Increment with wrap: reg[0]=63, src_a=0, la=1, alu_s=11, lr, er, ea, dst=0 -> reg[0]=0, cout=1, zero=1.
REQ-025 Compare: reg[1]=59 via key load, then src_a=1, src_b=6 with reg[6]=59, alu_s=10, cin=1, ea -> eq=1, zero=1, cout=1.
REQ-026 clear in the EXEC cycle of an op with er=1, dst=3 -> reg[3] stays 0, no done pulse, op_ready=1 on the next cycle.
REQ-027 er=1, dst=12 -> bad_dst pulse together with done, and all rd_data unchanged.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock/calendar datapath: field indices,
// ALU operation encodings, FSM states and the captured micro-op layout.
package clock_pkg;

   localparam int WIDTH      = 6;
   localparam int NUM_FIELDS = 10;

   localparam logic [3:0] SEC1  = 4'd0;
   localparam logic [3:0] SEC2  = 4'd1;
   localparam logic [3:0] MIN1  = 4'd2;
   localparam logic [3:0] MIN2  = 4'd3;
   localparam logic [3:0] HOUR1 = 4'd4;
   localparam logic [3:0] HOUR2 = 4'd5;
   localparam logic [3:0] DATE  = 4'd6;
   localparam logic [3:0] MONTH = 4'd7;
   localparam logic [3:0] DAY   = 4'd8;
   localparam logic [3:0] YEAR  = 4'd9;

   typedef enum logic [1:0] {
      ALU_PASS = 2'b00,
      ALU_ADD  = 2'b01,
      ALU_SUB  = 2'b10,
      ALU_INC  = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0]       src_a;
      logic [3:0]       src_b;
      logic [3:0]       dst;
      logic             la;
      logic             lb;
      logic             kc;
      logic             lr;
      logic             er;
      logic             ea;
      alu_op_t          alu_s;
      logic             cin;
      logic [WIDTH-1:0] key_data;
   } op_t;

   // Indices above YEAR name no field and are treated as holes.
   function automatic logic valid_index(input logic [3:0] idx);
      return idx <= YEAR;
   endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational 6-bit ALU with a 7-bit internal sum; bit 6 is the carry-out
// and everything wraps modulo 64.
module dp_alu
   import clock_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_t          s,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = '0;
      case (s)
         ALU_PASS: sum = {1'b0, a};
         ALU_ADD:  sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
         ALU_SUB:  sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
         ALU_INC:  sum = {1'b0, a} + (WIDTH+1)'(1);
         default:  sum = '0;
      endcase
   end

   assign result = sum[WIDTH-1:0];
   assign cout   = sum[WIDTH];

endmodule

// File: rtl/clock_datapath.sv
// Register file, operand latches, result register and the four-state
// micro-op sequencer of the clock/calendar datapath.
module clock_datapath
   import clock_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [3:0]       src_a,
   input  logic [3:0]       src_b,
   input  logic [3:0]       dst,
   input  logic             la,
   input  logic             lb,
   input  logic             kc,
   input  logic             lr,
   input  logic             er,
   input  logic             ea,
   input  logic [1:0]       alu_s,
   input  logic             cin,
   input  logic [WIDTH-1:0] key_data,
   input  logic [3:0]       rd_idx,
   output logic [WIDTH-1:0] rd_data,
   output logic             cout,
   output logic             zero,
   output logic             eq,
   output logic             done,
   output logic             bad_dst
);

   state_t           state;
   op_t              op;
   logic [WIDTH-1:0] regs [NUM_FIELDS];
   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] read_a;
   logic [WIDTH-1:0] read_b;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cout;

   assign op_ready = (state == IDLE);

   // Holes in the index space read as zero on every read port.
   always_comb begin
      rd_data = '0;
      read_a  = '0;
      read_b  = '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         if (rd_idx == 4'(i))   rd_data = regs[i];
         if (op.src_a == 4'(i)) read_a  = regs[i];
         if (op.src_b == 4'(i)) read_b  = regs[i];
      end
   end

   dp_alu u_alu (
      .a      (lat_a),
      .b      (lat_b),
      .s      (op.alu_s),
      .cin    (op.cin),
      .result (alu_res),
      .cout   (alu_cout)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         state   <= IDLE;
         op      <= '0;
         lat_a   <= '0;
         lat_b   <= '0;
         res_r   <= '0;
         cout    <= 1'b0;
         zero    <= 1'b0;
         eq      <= 1'b0;
         done    <= 1'b0;
         bad_dst <= 1'b0;
         for (int i = 0; i < NUM_FIELDS; i++) regs[i] <= '0;
      end else begin
         done    <= 1'b0;
         bad_dst <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid) begin
                  op <= '{src_a: src_a, src_b: src_b, dst: dst, la: la, lb: lb,
                          kc: kc, lr: lr, er: er, ea: ea,
                          alu_s: alu_op_t'(alu_s), cin: cin, key_data: key_data};
                  state <= LATCH;
               end
            end
            LATCH: begin
               if (op.la) lat_a <= read_a;
               if (op.lb) lat_b <= op.kc ? op.key_data : read_b;
               state <= EXEC;
            end
            EXEC: begin
               if (op.lr) res_r <= alu_res;
               if (op.ea) begin
                  cout <= alu_cout;
                  zero <= (alu_res == '0);
                  eq   <= (lat_a == lat_b);
               end
               // done and bad_dst are registered so they pulse during WRITE.
               done    <= 1'b1;
               bad_dst <= op.er && !valid_index(op.dst);
               state   <= WRITE;
            end
            WRITE: begin
               if (op.er) begin
                  for (int i = 0; i < NUM_FIELDS; i++)
                     if (op.dst == 4'(i)) regs[i] <= res_r;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clock_datapath.sv
// Scoreboard bench for clock_datapath: a behavioural model predicts each
// micro-op's flags and register effects; a monitor checks them at done.
module tb_clock_datapath;

   logic       clk;
   logic       clear;
   logic       op_valid;
   logic       op_ready;
   logic [3:0] src_a;
   logic [3:0] src_b;
   logic [3:0] dst;
   logic       la;
   logic       lb;
   logic       kc;
   logic       lr;
   logic       er;
   logic       ea;
   logic [1:0] alu_s;
   logic       cin;
   logic [5:0] key_data;
   logic [3:0] rd_idx;
   logic [5:0] rd_data;
   logic       cout;
   logic       zero;
   logic       eq;
   logic       done;
   logic       bad_dst;

   typedef struct {
      logic [3:0] dst;
      logic       bad;
      logic       c;
      logic       z;
      logic       e;
      int         acc;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   cycle = 0;
   int   last_accept = 0;
   int   regs_m[16];
   int   a_m;
   int   b_m;
   int   r_m;
   logic c_m;
   logic z_m;
   logic e_m;
   logic prev_done = 1'b0;

   clock_datapath dut (
      .clk      (clk),
      .clear    (clear),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .src_a    (src_a),
      .src_b    (src_b),
      .dst      (dst),
      .la       (la),
      .lb       (lb),
      .kc       (kc),
      .lr       (lr),
      .er       (er),
      .ea       (ea),
      .alu_s    (alu_s),
      .cin      (cin),
      .key_data (key_data),
      .rd_idx   (rd_idx),
      .rd_data  (rd_data),
      .cout     (cout),
      .zero     (zero),
      .eq       (eq),
      .done     (done),
      .bad_dst  (bad_dst)
   );

   initial begin
      clk = 1'b0;
      forever #50 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   // Scoreboard monitor: every done pulse must match the oldest prediction.
   always @(negedge clk) begin
      if (prev_done === 1'b1) begin
         total++;
         if (done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL done_width done=%b required 0", done);
         end
      end
      if (done === 1'b1) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_done done=1 required no pulse");
         end else begin
            mon_e = sbq.pop_front();
            if (cycle - mon_e.acc != 3) begin
               bad++;
               $display("[TB] FAIL latency got=%0d required 3", cycle - mon_e.acc);
            end
            total++;
            if (bad_dst !== mon_e.bad) begin
               bad++;
               $display("[TB] FAIL bad_dst got=%b required %b (dst=%0d)", bad_dst, mon_e.bad, mon_e.dst);
            end
            total++;
            if ({cout, zero, eq} !== {mon_e.c, mon_e.z, mon_e.e}) begin
               bad++;
               $display("[TB] FAIL flags cout/zero/eq got=%b%b%b required %b%b%b",
                        cout, zero, eq, mon_e.c, mon_e.z, mon_e.e);
            end
            total++;
            if (op_ready !== 1'b0) begin
               bad++;
               $display("[TB] FAIL ready_in_write got=%b required 0", op_ready);
            end
         end
      end
      prev_done = done;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic model_reset();
      for (int i = 0; i < 16; i++) regs_m[i] = 0;
      a_m = 0;
      b_m = 0;
      r_m = 0;
      c_m = 1'b0;
      z_m = 1'b0;
      e_m = 1'b0;
      sbq.delete();
   endtask

   task automatic scramble_fields();
      src_a    = 4'($urandom);
      src_b    = 4'($urandom);
      dst      = 4'($urandom);
      la       = 1'($urandom);
      lb       = 1'($urandom);
      kc       = 1'($urandom);
      lr       = 1'($urandom);
      er       = 1'($urandom);
      ea       = 1'($urandom);
      alu_s    = 2'($urandom);
      cin      = 1'($urandom);
      key_data = 6'($urandom);
   endtask

   // Pulses clear for one edge, optionally with a valid op presented alongside.
   task automatic do_clear(input logic with_op);
      @(negedge clk);
      clear = 1'b1;
      scramble_fields();
      op_valid = with_op;
      @(negedge clk);
      clear    = 1'b0;
      op_valid = 1'b0;
      model_reset();
   endtask

   // Issues one micro-op, predicts its effect and waits for its completion.
   task automatic run_op(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] d,
                         input logic fla, input logic flb, input logic fkc,
                         input logic flr, input logic fer, input logic fea,
                         input logic [1:0] s, input logic c, input logic [5:0] kd);
      int   n;
      int   sum;
      exp_t ex;
      n = 0;
      while (op_ready !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (op_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ready_timeout op_ready=%b required 1", op_ready);
      end
      src_a = sa; src_b = sb; dst = d;
      la = fla; lb = flb; kc = fkc; lr = flr; er = fer; ea = fea;
      alu_s = s; cin = c; key_data = kd;
      op_valid = 1'b1;
      @(posedge clk);
      last_accept = cycle;
      if (fla) a_m = regs_m[sa];
      if (flb) b_m = fkc ? int'(kd) : regs_m[sb];
      case (s)
         2'b00:   sum = a_m;
         2'b01:   sum = a_m + b_m + int'(c);
         2'b10:   sum = a_m + (63 - b_m) + int'(c);
         default: sum = a_m + 1;
      endcase
      if (flr) r_m = sum % 64;
      if (fea) begin
         c_m = (sum >= 64);
         z_m = ((sum % 64) == 0);
         e_m = (a_m == b_m);
      end
      if (fer && d < 10) regs_m[d] = r_m;
      ex.dst = d;
      ex.bad = fer && (d >= 10);
      ex.c   = c_m;
      ex.z   = z_m;
      ex.e   = e_m;
      ex.acc = last_accept;
      sbq.push_back(ex);
      #1;
      scramble_fields();
      op_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 8);
      op_valid = 1'b0;
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("[TB] FAIL done_timeout done=%b required 1 within 8 cycles", done);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_clear(1'b1);
      total++;
      if (op_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_ready got=%b required 1", op_ready);
      end
      total++;
      if ({cout, zero, eq, done, bad_dst} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags got=%b required 00000", {cout, zero, eq, done, bad_dst});
      end
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         total++;
         if (rd_data !== 6'd0) begin
            bad++;
            $display("[TB] FAIL reset_reg[%0d] got=%0d required 0", i, rd_data);
         end
      end
   endtask

   task automatic test_keypad();
      run_op(4'd0, 4'd0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 6'd37);
      rd_idx = 4'd2;
      #1;
      total++;
      if (rd_data !== 6'd37) begin
         bad++;
         $display("[TB] FAIL keypad_reg2 got=%0d required 37", rd_data);
      end
   endtask

   task automatic test_inc_wrap();
      run_op(4'd5, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 6'd63);
      run_op(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 6'd0);
      rd_idx = 4'd0;
      #1;
      total++;
      if (rd_data !== 6'd0 || cout !== 1'b1 || zero !== 1'b1) begin
         bad++;
         $display("[TB] FAIL inc_wrap reg0=%0d cout=%b zero=%b required 0 1 1", rd_data, cout, zero);
      end
   endtask

   task automatic test_compare();
      run_op(4'd5, 4'd0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 6'd59);
      run_op(4'd5, 4'd0, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 6'd59);
      run_op(4'd1, 4'd6, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 6'd0);
      total++;
      if ({eq, zero, cout} !== 3'b111) begin
         bad++;
         $display("[TB] FAIL compare eq/zero/cout got=%b%b%b required 111", eq, zero, cout);
      end
      rd_idx = 4'd6;
      #1;
      total++;
      if (rd_data !== 6'd59) begin
         bad++;
         $display("[TB] FAIL compare_reg6 got=%0d required 59", rd_data);
      end
   endtask

   task automatic test_hold_r();
      run_op(4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 6'd0);
      run_op(4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 6'd0);
      rd_idx = 4'd7;
      #1;
      total++;
      if (rd_data !== 6'd37) begin
         bad++;
         $display("[TB] FAIL hold_r_reg7 got=%0d required 37", rd_data);
      end
      run_op(4'd2, 4'd0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 6'd5);
      rd_idx = 4'd2;
      #1;
      total++;
      if (rd_data !== 6'd42) begin
         bad++;
         $display("[TB] FAIL same_src_dst_reg2 got=%0d required 42", rd_data);
      end
   endtask

   task automatic test_bad_dst();
      run_op(4'd2, 4'd0, 4'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 6'd0);
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         total++;
         if (rd_data !== 6'(regs_m[i])) begin
            bad++;
            $display("[TB] FAIL bad_dst_reg[%0d] got=%0d required %0d", i, rd_data, regs_m[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int first;
      run_op(4'd6, 4'd1, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 6'd0);
      first = last_accept;
      run_op(4'd8, 4'd8, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 6'd0);
      total++;
      if (last_accept - first != 4) begin
         bad++;
         $display("[TB] FAIL back_to_back spacing got=%0d required 4", last_accept - first);
      end
      for (int k = 0; k < 10; k++) begin
         run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 2'($urandom), 1'($urandom), 6'($urandom));
      end
      for (int i = 0; i < 16; i++) begin
         rd_idx = 4'(i);
         #1;
         total++;
         if (rd_data !== 6'(regs_m[i])) begin
            bad++;
            $display("[TB] FAIL random_reg[%0d] got=%0d required %0d", i, rd_data, regs_m[i]);
         end
      end
   endtask

   task automatic test_abort();
      @(negedge clk);
      src_a = 4'd5; src_b = 4'd0; dst = 4'd3;
      la = 1'b1; lb = 1'b1; kc = 1'b1; lr = 1'b1; er = 1'b1; ea = 1'b1;
      alu_s = 2'b01; cin = 1'b0; key_data = 6'd9;
      op_valid = 1'b1;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      total++;
      if (op_ready !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_state op_ready=%b done=%b required 1 0", op_ready, done);
      end
      for (int k = 0; k < 6; k++) begin
         rd_idx = 4'd3;
         #1;
         total++;
         if (done !== 1'b0 || rd_data !== 6'd0) begin
            bad++;
            $display("[TB] FAIL abort_no_write done=%b reg3=%0d required 0 0", done, rd_data);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      clear    = 1'b0;
      op_valid = 1'b0;
      rd_idx   = 4'd0;
      scramble_fields();
      model_reset();
      test_reset();
      test_keypad();
      test_inc_wrap();
      test_compare();
      test_hold_r();
      test_bad_dst();
      test_back_to_back();
      test_abort();
      test_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
